rim_tape_loader: RTL and testbench

RIM_TAPE_LOADER -- requirements
Module: rim_tape_loader

---
 rtl/rim_tape_loader_if.sv | 20 ++
 rtl/rim_tape_loader.sv | 132 +++++++++++++
 tb/tb_rim_tape_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rim_tape_loader_if.sv
// Paper-tape reader handshake plus RAM port-B write bus used by the RIM loader.
// The master side is the reader/RAM environment, the slave side is the loader.
interface rim_tape_loader_if;
    logic [7:0]  tape_data;
    logic        tape_valid;
    logic        tape_ready;
    logic [11:0] address_b;
    logic [17:0] data_b;
    logic        wren_b;

    modport master (
        output tape_data, tape_valid,
        input  tape_ready, address_b, data_b, wren_b
    );

    modport slave (
        input  tape_data, tape_valid,
        output tape_ready, address_b, data_b, wren_b
    );
endinterface

// File: rtl/rim_tape_loader.sv
// RIM-format paper-tape loader: assembles 18-bit words from three channel-8
// frames, deposits DIO/data pairs into RAM port B and stops on a JMP word.
module rim_tape_loader #(
    parameter logic [5:0] DIO_OP = 6'o32,
    parameter logic [5:0] JMP_OP = 6'o60
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    rim_tape_loader_if.slave      bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [11:0]           start_address,
    output logic [12:0]           word_count
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_GET_ADDR, ST_GET_DATA, ST_WRITE, ST_DONE, ST_ERR
    } state_t;

    state_t      state, state_next;
    logic [1:0]  frame_cnt;
    logic [11:0] asm_hi;
    logic [11:0] target_addr;
    logic [11:0] address_q;
    logic [17:0] data_q;
    logic        tape_ready_c;
    logic        wren_c;

    function automatic logic [12:0] sat_inc(input logic [12:0] cnt);
        return (cnt == 13'd4096) ? cnt : cnt + 13'd1;
    endfunction

    // Only the upper two frames are kept; the third arrives on the completing edge.
    logic        hole_frame;
    logic        word_done;
    logic [17:0] word_c;
    logic        start_ok;
    logic        unused_frame_bit;

    assign hole_frame       = bus.tape_valid && tape_ready_c && bus.tape_data[7];
    assign word_done        = hole_frame && (frame_cnt == 2'd2);
    assign word_c           = {asm_hi, bus.tape_data[5:0]};
    assign start_ok         = load_start &&
                              (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign unused_frame_bit = bus.tape_data[6];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR:
                if (load_start) state_next = ST_GET_ADDR;
            ST_GET_ADDR:
                if (word_done) begin
                    if (word_c[17:12] == DIO_OP)      state_next = ST_GET_DATA;
                    else if (word_c[17:12] == JMP_OP) state_next = ST_DONE;
                    else                              state_next = ST_ERR;
                end
            ST_GET_DATA:
                if (word_done) state_next = ST_WRITE;
            ST_WRITE:
                state_next = ST_GET_ADDR;
            default:
                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tape_ready_c = 1'b0;
        wren_c       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        case (state)
            ST_GET_ADDR, ST_GET_DATA: begin
                tape_ready_c = 1'b1;
                busy         = 1'b1;
            end
            ST_WRITE: begin
                wren_c = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE: done  = 1'b1;
            ST_ERR:  error = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_cnt     <= 2'd0;
            asm_hi        <= 12'd0;
            target_addr   <= 12'd0;
            address_q     <= 12'd0;
            data_q        <= 18'd0;
            start_address <= 12'd0;
            word_count    <= 13'd0;
        end else begin
            if (start_ok) begin
                frame_cnt  <= 2'd0;
                asm_hi     <= 12'd0;
                word_count <= 13'd0;
            end else if (hole_frame) begin
                frame_cnt <= (frame_cnt == 2'd2) ? 2'd0 : frame_cnt + 2'd1;
                asm_hi    <= {asm_hi[5:0], bus.tape_data[5:0]};
            end

            // Port-B address/data are loaded on the edge entering WRITE and then held.
            if (word_done && state == ST_GET_ADDR) begin
                if (word_c[17:12] == DIO_OP)      target_addr   <= word_c[11:0];
                else if (word_c[17:12] == JMP_OP) start_address <= word_c[11:0];
            end
            if (word_done && state == ST_GET_DATA) begin
                address_q <= target_addr;
                data_q    <= word_c;
            end
            if (state == ST_WRITE) word_count <= sat_inc(word_count);
        end
    end

    assign bus.tape_ready = tape_ready_c;
    assign bus.wren_b     = wren_c;
    assign bus.address_b  = address_q;
    assign bus.data_b     = data_q;

endmodule

// File: tb/tb_rim_tape_loader.sv
// Directed bench for the RIM tape loader; RAM writes are checked against a
// scoreboard queue filled as each data word is put on tape.
module tb_rim_tape_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load_start = 1'b0;
    logic        busy, done, error;
    logic [11:0] start_address;
    logic [12:0] word_count;

    rim_tape_loader_if bus ();

    rim_tape_loader dut (
        .clock         (clock),
        .reset         (reset),
        .load_start    (load_start),
        .bus           (bus.slave),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .start_address (start_address),
        .word_count    (word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] addr;
        logic [17:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    // Leader blanks, DIO 0o320100 (0o32 in the low six bits is 0x1A), trailing blank, data 0o010203.
    logic [7:0] f_load1 [9] = '{8'h00, 8'h00, 8'h9A, 8'h81, 8'h80, 8'h00, 8'h81, 8'h82, 8'h83};
    logic [7:0] f_jmp   [3] = '{8'hB0, 8'h80, 8'h94};
    logic [7:0] f_bad   [3] = '{8'hBF, 8'h80, 8'h80};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f, input bit jitter);
        int n;
        bit rdy;
        if (jitter) begin
            repeat ($urandom_range(0, 2)) begin
                bus.tape_valid = 1'b0;
                bus.tape_data  = 8'($urandom);
                tick();
            end
        end
        bus.tape_data  = f;
        bus.tape_valid = 1'b1;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clock);
            rdy = bus.tape_ready;
            tick();
            n++;
        end
        bus.tape_valid = 1'b0;
        if (!rdy) check("frame_accept_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic send_word(input logic [17:0] w);
        send_frame({2'b10, w[17:12]}, 1'b0);
        send_frame({2'b10, w[11:6]}, 1'b0);
        send_frame({2'b10, w[5:0]}, 1'b0);
    endtask

    task automatic expect_write(input logic [11:0] a, input logic [17:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    always @(negedge clock) begin
        if (!reset && bus.wren_b === 1'b1) begin
            check("write_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                wr_t w;
                w = sb.pop_front();
                check("wr_address_b", 32'(bus.address_b), 32'(w.addr));
                check("wr_data_b", 32'(bus.data_b), 32'(w.data));
            end
        end
    end

    initial begin
        bus.tape_data  = 8'h00;
        bus.tape_valid = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (2) tick();
        check("rst_tape_ready", 32'(bus.tape_ready), 32'd0);
        check("rst_wren_b", 32'(bus.wren_b), 32'd0);
        check("rst_flags", {busy, done, error}, 32'd0);
        check("rst_address_b", 32'(bus.address_b), 32'd0);
        check("rst_data_b", 32'(bus.data_b), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b0;
        tick();

        // First load: one DIO/data pair with leader blanks
        pulse_start();
        check("load_busy", 32'(busy), 32'd1);
        check("load_tape_ready", 32'(bus.tape_ready), 32'd1);
        expect_write(12'o0100, 18'o010203);
        foreach (f_load1[i]) send_frame(f_load1[i], 1'b0);
        check("latency_wren_b", 32'(bus.wren_b), 32'd1);
        tick();
        check("wren_one_cycle", 32'(bus.wren_b), 32'd0);
        check("hold_address_b", 32'(bus.address_b), 32'o0100);
        check("hold_data_b", 32'(bus.data_b), 32'o010203);
        check("count_after_one", 32'(word_count), 32'd1);

        // Terminating JMP
        foreach (f_jmp[i]) send_frame(f_jmp[i], 1'b0);
        check("jmp_done", 32'(done), 32'd1);
        check("jmp_busy", 32'(busy), 32'd0);
        check("jmp_start_address", 32'(start_address), 32'o0024);
        check("jmp_tape_ready", 32'(bus.tape_ready), 32'd0);
        repeat (3) tick();
        check("done_held", 32'(done), 32'd1);

        // New load with load_start during GET_DATA, then overwrite of the same address
        pulse_start();
        check("restart_done_clear", 32'(done), 32'd0);
        check("restart_count_clear", 32'(word_count), 32'd0);
        expect_write(12'o7777, 18'o123456);
        send_word(18'o327777);
        send_frame(8'h8A, 1'b0);
        pulse_start();
        send_frame(8'h9C, 1'b0);
        send_frame(8'hAE, 1'b0);
        check("ignored_start_wren", 32'(bus.wren_b), 32'd1);
        expect_write(12'o7777, 18'o765432);
        send_word(18'o327777);
        send_word(18'o765432);
        tick();
        check("overwrite_count", 32'(word_count), 32'd2);

        // Illegal address word
        send_frame(f_bad[0], 1'b0);
        send_frame(f_bad[1], 1'b0);
        send_frame(f_bad[2], 1'b0);
        check("bad_error", 32'(error), 32'd1);
        check("bad_busy", 32'(busy), 32'd0);
        check("bad_count_kept", 32'(word_count), 32'd2);
        pulse_start();
        check("err_clear", 32'(error), 32'd0);
        check("err_restart_busy", 32'(busy), 32'd1);

        // Jittered valid with blank frames between every real frame
        expect_write(12'o0100, 18'o010203);
        foreach (f_load1[i]) begin
            send_frame(f_load1[i], 1'b1);
            if (i < 8) send_frame(8'h7F - 8'($urandom_range(0, 63)), 1'b1);
        end
        tick();
        check("jitter_count", 32'(word_count), 32'd1);
        foreach (f_jmp[i]) begin
            send_frame(8'h40, 1'b1);
            send_frame(f_jmp[i], 1'b1);
        end
        check("jitter_done", 32'(done), 32'd1);
        check("jitter_start_address", 32'(start_address), 32'o0024);

        // Reset mid-word abandons the partial word
        pulse_start();
        send_word(18'o320200);
        send_frame(8'h81, 1'b0);
        send_frame(8'h82, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_flags", {busy, done, error}, 32'd0);
        check("midrst_start_address", 32'(start_address), 32'd0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        check("midrst_ready", 32'(bus.tape_ready), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        pulse_start();
        expect_write(12'o0005, 18'o000777);
        send_word(18'o320005);
        send_frame(8'h80, 1'b0);
        send_frame(8'h87, 1'b0);
        send_frame(8'hBF, 1'b0);
        check("fresh_wren", 32'(bus.wren_b), 32'd1);
        tick();
        check("fresh_count", 32'(word_count), 32'd1);

        repeat (5) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
